// File: rtl/csa_nibble_sequencer_if.sv
// Operand/result bus for csa_nibble_sequencer.
// master: producer/consumer side (drives operands and out_ready).
// slave : adder side (drives in_ready, result and status).
// The ovf signal exists only when CSA_OVF_DETECT_EN is defined.
interface csa_nibble_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CSA_OVF_DETECT_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/csa_nibble_sequencer.sv
// Sequenced WIDTH-bit adder built on one shared 4-bit carry-select slice.
// One nibble is committed per cycle; the result is presented after WIDTH/4
// cycles and held until the consumer takes it.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   io     - slave side of csa_nibble_sequencer_if: in_valid/in_ready with
//            a, b, cin; out_valid/out_ready with sum, cout; busy status.
// Optional feature: define CSA_OVF_DETECT_EN to add the signed-overflow
// output io.ovf.
module csa_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    csa_nibble_sequencer_if.slave  io
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = $clog2(NIBBLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH == 0) begin : g_bad_width
        $error("csa_nibble_sequencer: WIDTH must be a nonzero multiple of 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef CSA_OVF_DETECT_EN
    logic             ovf_q, ovf_d;
`endif

    logic [3:0] a_nib, b_nib;
    logic [4:0] s0, s1, sel;

    // Carry-select slice on the nibble addressed by idx
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[n*4 +: 4];
                b_nib = b_q[n*4 +: 4];
            end
        end
        s0  = {1'b0, a_nib} + {1'b0, b_nib};
        s1  = s0 + 5'd1;
        sel = carry_q ? s1 : s0;
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CSA_OVF_DETECT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    state_d = S_RUN;
                    a_d     = io.a;
                    b_d     = io.b;
                    carry_d = io.cin;
                    idx_d   = '0;
                    sum_d   = '0;
`ifdef CSA_OVF_DETECT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                for (int unsigned n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[n*4 +: 4] = sel[3:0];
                    end
                end
                carry_d = sel[4];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = sel[4];
                    state_d = S_DONE;
`ifdef CSA_OVF_DETECT_EN
                    // sel[3] is the MSB of the final sum here
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sel[3] != a_q[WIDTH-1]);
`endif
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flops track the state being entered so they line up with it
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CSA_OVF_DETECT_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef CSA_OVF_DETECT_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.busy      = busy_q;
`ifdef CSA_OVF_DETECT_EN
    assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Self-checking bench for csa_nibble_sequencer (WIDTH=16).
module tb_csa_nibble_sequencer;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csa_nibble_sequencer_if #(.WIDTH(WIDTH)) io ();

    csa_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with latency, result and handshake checks
    task automatic run_op(input string name, input vec_t v);
        int cnt;
        cnt = 0;
        io.a = v.a; io.b = v.b; io.cin = v.cin; io.in_valid = 1'b1;
        while (!io.in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        check({name, "_in_ready"}, 32'(io.in_ready), 32'd1);
        tick();
        // scramble inputs after accept; they must have no effect
        io.in_valid = 1'b0; io.a = ~v.a; io.b = 16'h5A5A; io.cin = ~v.cin;
        check({name, "_busy"}, 32'(io.busy), 32'd1);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!io.out_valid && cnt < 20);
        check({name, "_latency"}, 32'(cnt), 32'(NIBBLES));
        check({name, "_sum"}, 32'(io.sum), 32'(v.sum));
        check({name, "_cout"}, 32'(io.cout), 32'(v.cout));
`ifdef CSA_OVF_DETECT_EN
        check({name, "_ovf"}, 32'(io.ovf), 32'(v.ovf));
`endif
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        check({name, "_out_valid_drop"}, 32'(io.out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(io.in_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        int sent;
        int got;
        int cyc;
        int last_acc;
        int bad_gap;
        logic pend;
        logic [16:0] full;
        vec_t e;
        vec_t v;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(io.in_ready), 32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_busy", 32'(io.busy), 32'd0);
        check("rst_sum", 32'(io.sum), 32'd0);
        check("rst_cout", 32'(io.cout), 32'd0);
`ifdef CSA_OVF_DETECT_EN
        check("rst_ovf", 32'(io.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(io.in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure in DONE with competing in_valid
        io.a = 16'h1234; io.b = 16'h0FFF; io.cin = 1'b0; io.in_valid = 1'b1;
        tick();
        io.a = 16'hFFFF; io.b = 16'hFFFF; io.cin = 1'b1;
        cnt = 0;
        while (!io.out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_sum%0d", k), 32'(io.sum), 32'h2233);
            check($sformatf("bp_cout%0d", k), 32'(io.cout), 32'd0);
            check($sformatf("bp_in_ready%0d", k), 32'(io.in_ready), 32'd0);
            check($sformatf("bp_out_valid%0d", k), 32'(io.out_valid), 32'd1);
            tick();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(io.in_ready), 32'd1);
        check("bp_idle_busy", 32'(io.busy), 32'd0);
        run_op("bp_next", vecs[8]);

        // Reset after two committed nibbles
        io.a = 16'hFFFF; io.b = 16'h0001; io.cin = 1'b0; io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(io.busy), 32'd0);
        check("midrst_out_valid", 32'(io.out_valid), 32'd0);
        tick();
        check("midrst_in_ready", 32'(io.in_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (io.out_valid) cnt++;
            tick();
        end
        check("midrst_no_out_valid", 32'(cnt), 32'd0);
        v = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        run_op("midrst_next", v);

        // Back-to-back random stream with both sides always ready
        io.out_ready = 1'b1;
        io.a = 16'($urandom); io.b = 16'($urandom); io.cin = 1'($urandom);
        io.in_valid = 1'b1;
        sent = 0; got = 0; cyc = 0; last_acc = -1; bad_gap = 0; pend = 1'b0;
        while (got < 100 && cyc < 2000) begin
            if (io.out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b_sum%0d", got), 32'(io.sum), 32'(e.sum));
                    check($sformatf("b2b_cout%0d", got), 32'(io.cout), 32'(e.cout));
`ifdef CSA_OVF_DETECT_EN
                    check($sformatf("b2b_ovf%0d", got), 32'(io.ovf), 32'(e.ovf));
`endif
                end
                got++;
            end
            if (io.in_ready && io.in_valid) begin
                full = {1'b0, io.a} + {1'b0, io.b} + {16'd0, io.cin};
                e.a = io.a; e.b = io.b; e.cin = io.cin;
                e.sum = full[15:0];
                e.cout = full[16];
                e.ovf = (io.a[15] == io.b[15]) && (full[15] != io.a[15]);
                exp_q.push_back(e);
                pend = 1'b1;
            end
            tick();
            cyc++;
            if (pend) begin
                if (last_acc >= 0 && (cyc - last_acc) != NIBBLES + 2) bad_gap++;
                last_acc = cyc;
                sent++;
                pend = 1'b0;
                io.a = 16'($urandom); io.b = 16'($urandom); io.cin = 1'($urandom);
                if (sent >= 100) io.in_valid = 1'b0;
            end
        end
        io.out_ready = 1'b0;
        check("b2b_results", 32'(got), 32'd100);
        check("b2b_interval_violations", 32'(bad_gap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
